// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// special-case result constants and operand-signedness helpers.
package exe_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Constants are kept at the widest supported XLEN and sliced by the user.
    localparam int unsigned MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] DIV0_QUOT_C   = {MAX_XLEN{1'b1}};
    localparam logic [MAX_XLEN-1:0] OVF_REM_C     = {MAX_XLEN{1'b0}};
    localparam logic [MAX_XLEN-1:0] ILLEGAL_RES_C = {MAX_XLEN{1'b0}};

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_signed_b(input op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exe_muldiv_special.sv
// Divide-by-zero / signed-overflow detection and short-circuit result selection.
// Division support is present only when EXE_MULDIV_DIV_EN is defined.
module muldiv_special
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_e             op_i,
`ifdef EXE_MULDIV_DIV_EN
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
`endif
    output logic            bypass_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

`ifdef EXE_MULDIV_DIV_EN
    logic div0_s;
    logic ovf_s;

    assign div0_s = (b_i == {XLEN{1'b0}});
    assign ovf_s  = (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
`endif

    // Select whether the request skips the iterative datapath and what it returns.
    always_comb begin
        bypass_o  = 1'b0;
        result_o  = ILLEGAL_RES_C[XLEN-1:0];
        illegal_o = 1'b0;
`ifdef EXE_MULDIV_DIV_EN
        if (op_is_div(op_i) && div0_s) begin
            bypass_o = 1'b1;
            result_o = op_i[1] ? a_i : DIV0_QUOT_C[XLEN-1:0];
        end else if (((op_i == OP_DIV) || (op_i == OP_REM)) && ovf_s) begin
            bypass_o = 1'b1;
            result_o = op_i[1] ? OVF_REM_C[XLEN-1:0] : a_i;
        end else begin
            bypass_o = 1'b0;
        end
`else
        if (op_is_div(op_i)) begin
            bypass_o  = 1'b1;
            illegal_o = 1'b1;
        end else begin
            bypass_o  = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative radix-2 multiply/divide unit, one bit per cycle on operand magnitudes.
// Divide ops are implemented only when EXE_MULDIV_DIV_EN is defined, otherwise flagged illegal.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    op_e              op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  m_q, hi_q, lo_q;
    logic             neg_q;
    logic             out_valid_q, out_illegal_q;
    logic [XLEN-1:0]  out_result_q;
    logic [TAG_W-1:0] out_tag_q;

    op_e              in_op_s;
    logic             a_neg_s, b_neg_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s;
    logic             bypass_s, spec_illegal_s;
    logic [XLEN-1:0]  spec_result_s;
    logic [XLEN:0]    mul_sum_s;
    logic [XLEN-1:0]  step_hi_s, step_lo_s, fin_result_s;
    logic [2*XLEN-1:0] prod_s;

    assign in_op_s  = op_e'(in_op);
    assign a_neg_s  = op_signed_a(in_op_s) && in_a[XLEN-1];
    assign b_neg_s  = op_signed_b(in_op_s) && in_b[XLEN-1];
    assign a_mag_s  = a_neg_s ? ({XLEN{1'b0}} - in_a) : in_a;
    assign b_mag_s  = b_neg_s ? ({XLEN{1'b0}} - in_b) : in_b;

    muldiv_special #(.XLEN(XLEN)) u_special (
        .op_i      (in_op_s),
`ifdef EXE_MULDIV_DIV_EN
        .a_i       (in_a),
        .b_i       (in_b),
`endif
        .bypass_o  (bypass_s),
        .result_o  (spec_result_s),
        .illegal_o (spec_illegal_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides accept and out_ready.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = in_valid ? (bypass_s ? ST_DONE : ST_CALC) : ST_IDLE;
                ST_CALC: state_d = (cnt_q == {CW{1'b0}}) ? ST_DONE : ST_CALC;
                ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM-derived handshake outputs.
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});

`ifdef EXE_MULDIV_DIV_EN
    logic [XLEN:0] div_shift_s, div_diff_s;
    assign div_shift_s = {hi_q, lo_q[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, m_q};
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        step_hi_s = mul_sum_s[XLEN:1];
        step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
`ifdef EXE_MULDIV_DIV_EN
        if (op_is_div(op_q)) begin
            if (!div_diff_s[XLEN]) begin
                step_hi_s = div_diff_s[XLEN-1:0];
                step_lo_s = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[XLEN-1:0];
                step_lo_s = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
`endif
    end

    // Sign correction and result-half selection applied to the final step.
    always_comb begin
        prod_s       = neg_q ? ({(2*XLEN){1'b0}} - {step_hi_s, step_lo_s}) : {step_hi_s, step_lo_s};
        fin_result_s = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef EXE_MULDIV_DIV_EN
        if (op_is_div(op_q)) begin
            fin_result_s = op_q[1] ? step_hi_s : step_lo_s;
            fin_result_s = neg_q ? ({XLEN{1'b0}} - fin_result_s) : fin_result_s;
        end else begin
            fin_result_s = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
`endif
    end

    // Operand capture, iteration registers and the registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= {CW{1'b0}};
            op_q          <= OP_MUL;
            tag_q         <= {TAG_W{1'b0}};
            m_q           <= {XLEN{1'b0}};
            hi_q          <= {XLEN{1'b0}};
            lo_q          <= {XLEN{1'b0}};
            neg_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= {XLEN{1'b0}};
            out_tag_q     <= {TAG_W{1'b0}};
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_op_s;
                        tag_q <= in_tag;
                        neg_q <= (op_is_div(in_op_s) && in_op_s[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
                        m_q   <= op_is_div(in_op_s) ? b_mag_s : a_mag_s;
                        lo_q  <= op_is_div(in_op_s) ? a_mag_s : b_mag_s;
                        hi_q  <= {XLEN{1'b0}};
                        cnt_q <= CW'(XLEN-1);
                        if (bypass_s) begin
                            out_valid_q   <= 1'b1;
                            out_result_q  <= spec_result_s;
                            out_tag_q     <= in_tag;
                            out_illegal_q <= spec_illegal_s;
                        end else begin
                            out_valid_q <= 1'b0;
                        end
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    hi_q <= step_hi_s;
                    lo_q <= step_lo_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        out_valid_q   <= 1'b1;
                        out_result_q  <= fin_result_s;
                        out_tag_q     <= tag_q;
                        out_illegal_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: directed vectors push expected responses, a monitor pops and checks.
// Divide expectations follow EXE_MULDIV_DIV_EN.
module tb_exe_muldiv;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic        busy;

`ifdef EXE_MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    exe_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on each new result, checks stability while held.
    initial begin
        logic        pv;
        logic [31:0] pr;
        logic [4:0]  pt;
        logic        pi;
        exp_t        e;
        pv = 1'b0; pr = 32'h0; pt = 5'h0; pi = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (out_valid && !pv) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_out: got result %h tag %h, expected no output", out_result, out_tag);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result", out_result, e.res);
                        chk("tag", 32'(out_tag), 32'(e.tag));
                        chk("illegal", 32'(out_illegal), 32'(e.ill));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("in_ready_done", 32'(in_ready), 32'h0);
                    end
                end else if (out_valid && pv) begin
                    chk("hold_result", out_result, pr);
                    chk("hold_tag", 32'(out_tag), 32'(pt));
                    chk("hold_illegal", 32'(out_illegal), 32'(pi));
                    chk("hold_in_ready", 32'(in_ready), 32'h0);
                end
                pv = out_valid; pr = out_result; pt = out_tag; pi = out_illegal;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit push, input logic [31:0] er,
                         input logic ei, input int el);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready %b, expected 1", in_ready);
        end else if (push) begin
            e.res = er; e.tag = tag; e.ill = ei; e.lat = el; e.acc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] er, input logic ei, input int el);
        issue(op, a, b, tag, 1'b1, er, ei, el);
        drain();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'b000;
        in_a = 32'h0; in_b = 32'h0; in_tag = 5'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_out_illegal", 32'(out_illegal), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Multiply vectors.
        run(3'b000, 32'd7,        32'hFFFFFFFD, 5'h11, 32'hFFFFFFEB, 1'b0, 33);
        run(3'b001, 32'h80000000, 32'h80000000, 5'h02, 32'h40000000, 1'b0, 33);
        run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 1'b0, 33);
        run(3'b010, 32'hFFFFFFFF, 32'd2,        5'h04, 32'hFFFFFFFF, 1'b0, 33);

        // Divide vectors: special cases, then a normal signed divide.
        run(3'b101, 32'd100, 32'd0, 5'h05, DIV_ON ? 32'hFFFFFFFF : 32'h0, !DIV_ON, 1);
        run(3'b111, 32'd100, 32'd0, 5'h06, DIV_ON ? 32'd100 : 32'h0, !DIV_ON, 1);
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'h07, DIV_ON ? 32'h80000000 : 32'h0, !DIV_ON, 1);
        run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'h08, 32'h0, !DIV_ON, 1);
        run(3'b100, 32'hFFFFFFF9, 32'd2, 5'h09, DIV_ON ? 32'hFFFFFFFD : 32'h0, !DIV_ON, DIV_ON ? 33 : 1);
        run(3'b110, 32'hFFFFFFF9, 32'd2, 5'h0A, DIV_ON ? 32'hFFFFFFFF : 32'h0, !DIV_ON, DIV_ON ? 33 : 1);

        // Flush ten cycles into the calculation.
        issue(3'b000, 32'd5, 32'd6, 5'h0B, 1'b0, 32'h0, 1'b0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        repeat (40) @(negedge clk);
        run(3'b000, 32'd3, 32'd4, 5'h0C, 32'd12, 1'b0, 33);

        // Asynchronous reset in the middle of an operation.
        issue(3'b011, 32'h1234, 32'h5678, 5'h0D, 1'b0, 32'h0, 1'b0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_out_tag", 32'(out_tag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Backpressure: hold out_ready low for five cycles in DONE.
        out_ready = 1'b0;
        issue(3'b000, 32'h12345678, 32'h10, 5'h1F, 1'b1, 32'h23456780, 1'b0, 33);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("bp_valid_held", 32'(out_valid), 32'h1);
        chk("bp_result_held", out_result, 32'h23456780);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 32'(out_valid), 32'h0);
        drain();
        run(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h15, 32'h1, 1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (power of two, >=8).
REQ-002 SHALL have parameter TAG_W, default 5, width of destination tag carried with each operation.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard any in-flight operation.
REQ-006 SHALL have port in_valid  input  1  and in_ready  output  1, request handshake; accept when both high.
REQ-007 SHALL have port in_op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports in_a, in_b  input  XLEN  operands; in_tag  input  TAG_W  destination tag.
REQ-009 SHALL have port out_valid  output  1  and out_ready  input  1, result handshake.
REQ-010 SHALL have ports out_result  output  XLEN; out_tag  output  TAG_W; out_illegal  output  1; busy  output  1 (state != IDLE).

Function
REQ-011 SHALL implement FSM IDLE, CALC, DONE; in_ready = (state == IDLE).
REQ-012 SHALL, on accept, latch op/tag/operand magnitudes, load counter with XLEN-1, and enter CALC.
REQ-013 SHALL perform one radix-2 step per CALC cycle (shift-add for multiply, restoring subtract for divide), decrementing the counter; CALC->DONE when counter == 0.
REQ-014 SHALL give normal latency of XLEN+1 cycles from the accept edge to out_valid high.
REQ-015 SHALL compute on magnitudes and apply sign correction on entry to DONE: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned; DIV quotient sign = a^b, REM sign = sign of a.
REQ-016 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH/MULHSU/MULHU.
REQ-017 SHALL bypass CALC (IDLE->DONE, latency 1) for divide by zero: DIV/DIVU -> all ones, REM/REMU -> in_a.
REQ-018 SHALL bypass CALC (latency 1) for signed overflow (in_a = most-negative, in_b = -1): DIV -> in_a, REM -> 0.
REQ-019 SHALL hold out_valid, out_result, out_tag and out_illegal stable in DONE until out_ready; DONE->IDLE on out_ready.
REQ-020 SHALL not accept a new request in the cycle DONE is left; the next accept occurs earliest one cycle later.
REQ-021 SHALL, on flush in any state, go to IDLE next edge, drop out_valid, and discard the result; flush takes priority over a same-cycle accept or out_ready.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, out_valid 0, out_result 0, out_tag 0, out_illegal 0, busy 0; in_ready is 1 during reset.
REQ-023 SHALL discard any in-flight operation on reset mid-operation, with no output produced after release.

Configuration
REQ-024 SHALL compile the divide datapath only when macro EXE_MULDIV_DIV_EN is defined; with it, ops 100-111 follow REQ-013..018 and out_illegal is always 0.
REQ-025 SHALL, without EXE_MULDIV_DIV_EN, complete ops 100-111 with latency 1, out_result 0, and out_illegal 1; multiply ops are unaffected.

Structure
REQ-026 SHALL take op encodings, FSM state encoding and special-case result constants from shared package exe_muldiv_pkg.
REQ-027 SHALL place the divide-by-zero/overflow detection and special-result selection in sub-module muldiv_special (combinational); the rest stays in exe_muldiv.

Verification
REQ-028 SHALL check MUL a=7, b=0xFFFFFFFD -> out_result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, tag echoed.
REQ-029 SHALL check MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 SHALL check DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each with latency 1.
REQ-031 SHALL check DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, latency 33.
REQ-032 SHALL check flush asserted 10 cycles into CALC -> out_valid never rises, in_ready high next cycle, and the following MUL 3*4 returns 12.
REQ-033 SHALL check out_ready held low 5 cycles in DONE -> outputs stable and in_ready low throughout; without EXE_MULDIV_DIV_EN, DIV -> out_illegal 1, result 0, latency 1.
